// File: rtl/aes_round_sequencer_pkg.sv
// Shared definitions for the AES round sequencer: key-size encodings, round
// limits, BCD digit width and the serial BCD converter state type.
package aes_seq_pkg;

  typedef enum logic [1:0] {
    MODE_128  = 2'd0,
    MODE_192  = 2'd1,
    MODE_256  = 2'd2,
    MODE_RSVD = 2'd3
  } aes_mode_e;

  typedef enum logic {
    BCD_IDLE  = 1'b0,
    BCD_SHIFT = 1'b1
  } bcd_state_e;

  localparam int MAX_ROUND   = 28;
  localparam int BCD_DIGIT_W = 4;

  // The reserved encoding runs as AES-128.
  function automatic logic [1:0] mode_norm(input logic [1:0] m);
    return (m == MODE_RSVD) ? 2'd0 : m;
  endfunction

  function automatic logic [4:0] nr_of(input logic [1:0] m);
    case (m)
      MODE_192: return 5'd12;
      MODE_256: return 5'd14;
      default:  return 5'd10;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Board-side bundle of the round sequencer: keys/switches and datapath bytes in,
// round control and display data out. auto_run exists only with AES_SEQ_AUTO_STEP_EN.
interface aes_round_sequencer_if
  import aes_seq_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 3,
  parameter int ROUND_W    = 5
);

  logic                              step;
  logic [1:0]                        mode;
  logic [DATA_W-1:0]                 cipher_byte;
  logic [DATA_W-1:0]                 decipher_byte;
  logic                              pt_match;
  logic [ROUND_W-1:0]                round;
  logic [1:0]                        act_mode;
  logic                              phase_dec;
  logic                              done;
  logic                              pass_led;
  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] disp_bcd;
  logic                              disp_valid;
`ifdef AES_SEQ_AUTO_STEP_EN
  logic                              auto_run;
`endif

  modport master (
    output step, mode, cipher_byte, decipher_byte, pt_match,
    input  round, act_mode, phase_dec, done, pass_led, disp_bcd, disp_valid
`ifdef AES_SEQ_AUTO_STEP_EN
    , output auto_run
`endif
  );

  modport slave (
    input  step, mode, cipher_byte, decipher_byte, pt_match,
    output round, act_mode, phase_dec, done, pass_led, disp_bcd, disp_valid
`ifdef AES_SEQ_AUTO_STEP_EN
    , input auto_run
`endif
  );

endinterface

// File: rtl/aes_round_sequencer_bcd_serial.sv
// Iterative double-dabble binary-to-BCD converter: one shift per clock, result
// published DATA_W+1 cycles after start; a new start aborts a running conversion.
module bcd_serial
  import aes_seq_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 3
)(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [DATA_W-1:0]                 value,
  output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcd,
  output logic                              busy,
  output logic                              valid
);

  localparam int BCD_W = BCD_DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  bcd_state_e        state;
  logic [DATA_W-1:0] sh;
  logic [BCD_W-1:0]  acc;
  logic [BCD_W-1:0]  adj;
  logic [BCD_W-1:0]  acc_next;
  logic [CNT_W-1:0]  cnt;

  // Add 3 to every digit that would overflow past 9 once doubled, then shift in the next bit.
  always_comb begin
    adj = acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc[BCD_DIGIT_W*i +: BCD_DIGIT_W] >= 4'd5)
        adj[BCD_DIGIT_W*i +: BCD_DIGIT_W] = acc[BCD_DIGIT_W*i +: BCD_DIGIT_W] + 4'd3;
    end
    acc_next = {adj[BCD_W-2:0], sh[DATA_W-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BCD_IDLE;
      sh    <= '0;
      acc   <= '0;
      cnt   <= '0;
      bcd   <= '0;
      valid <= 1'b0;
    end else if (start) begin
      state <= BCD_SHIFT;
      sh    <= value;
      acc   <= '0;
      cnt   <= CNT_W'(DATA_W);
      valid <= 1'b0;
    end else begin
      case (state)
        BCD_SHIFT: begin
          sh  <= sh << 1;
          acc <= acc_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bcd   <= acc_next;
            valid <= 1'b1;
            state <= BCD_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == BCD_SHIFT);

endmodule

// File: rtl/aes_round_sequencer.sv
// Round control for the AES demo: steps cipher then decipher rounds on key edges,
// converts the displayed byte to BCD and flags a plaintext match. Optional
// auto-stepping divider enabled by AES_SEQ_AUTO_STEP_EN.
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 3,
  parameter int ROUND_W    = 5
`ifdef AES_SEQ_AUTO_STEP_EN
  , parameter int AUTO_DIV = 50000000
`endif
)(
  input  logic                  clk,
  input  logic                  rst,
  aes_round_sequencer_if.slave  bus
);

  logic                 step_q;
  logic                 first_q;
  logic [ROUND_W-1:0]   round_q;
  logic [1:0]           act_mode_q;
  logic                 pass_q;
  logic [DATA_W-1:0]    last_val;
  logic [ROUND_W-1:0]   nr;
  logic [ROUND_W-1:0]   last_round;
  logic [DATA_W-1:0]    disp_src;
  logic                 key_edge;
  logic                 step_evt;
  logic                 conv_req;
  logic                 done_w;
  logic                 conv_busy;
  logic                 conv_valid;
  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] conv_bcd;

  assign nr         = ROUND_W'(nr_of(act_mode_q));
  assign last_round = nr + nr;
  assign done_w     = (round_q == last_round);
  assign key_edge   = bus.step & ~step_q;
  assign disp_src   = (round_q <= nr) ? bus.cipher_byte : bus.decipher_byte;
  assign conv_req   = first_q || (disp_src != last_val);

`ifdef AES_SEQ_AUTO_STEP_EN
  logic [31:0] div_cnt;
  logic        auto_pulse;

  assign auto_pulse = bus.auto_run && (div_cnt == 32'(AUTO_DIV - 1));
  assign step_evt   = key_edge | auto_pulse;

  always_ff @(posedge clk) begin
    if (rst || !bus.auto_run || auto_pulse)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 32'd1;
  end
`else
  assign step_evt = key_edge;
`endif

  // step_q resets high so a key held through reset does not count as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q     <= 1'b1;
      first_q    <= 1'b1;
      round_q    <= '0;
      act_mode_q <= 2'd0;
      pass_q     <= 1'b0;
      last_val   <= '0;
    end else begin
      step_q  <= bus.step;
      first_q <= 1'b0;
      pass_q  <= done_w & bus.pt_match;
      if (round_q == '0)
        act_mode_q <= mode_norm(bus.mode);
      if (step_evt && (round_q < last_round))
        round_q <= round_q + ROUND_W'(1);
      if (conv_req)
        last_val <= disp_src;
    end
  end

  bcd_serial #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_req),
    .value (disp_src),
    .bcd   (conv_bcd),
    .busy  (conv_busy),
    .valid (conv_valid)
  );

  assign bus.round      = round_q;
  assign bus.act_mode   = act_mode_q;
  assign bus.phase_dec  = (round_q > nr);
  assign bus.done       = done_w;
  assign bus.pass_led   = pass_q;
  assign bus.disp_bcd   = conv_bcd;
  assign bus.disp_valid = conv_valid & ~conv_busy;

endmodule
